// File: rtl/vlog_aes_apb_master.sv
// APB initiator that programs the AES-CBC peripheral for one 128-bit job, triggers it,
// polls status and returns the four result words over a valid/ready result port.
module vlog_aes_apb_master #(
  parameter int          VNAPBSLV      = 8,
  parameter int          VPINDEX       = 0,
  parameter logic [31:0] VPBASE        = 32'h0,
  parameter int          SETTLE_CYCLES = 4,
  parameter int          POLL_MAX      = 64
) (
  input  logic                vclk,
  input  logic                vrst,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic                job_mode,
  input  logic                job_key_ld,
  input  logic                job_iv_ld,
  input  logic [127:0]        job_key,
  input  logic [127:0]        job_iv,
  input  logic [127:0]        job_data,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [127:0]        res_data,
  output logic                res_err,
  output logic [0:VNAPBSLV-1] vpsel,
  output logic                vpenable,
  output logic [31:0]         vpaddr,
  output logic                vpwrite,
  output logic [31:0]         vpwdata,
  input  logic [31:0]         vprdata
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_SETUP, S_WR_ACCESS, S_SETTLE, S_POLL_SETUP,
    S_POLL_ACCESS, S_RD_SETUP, S_RD_ACCESS, S_DONE
  } state_t;

  localparam int CW = $clog2(POLL_MAX + SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] POLL_LAST   = CW'(POLL_MAX - 1);

  localparam logic [7:0] OFF_KEY  = 8'h00;
  localparam logic [7:0] OFF_DIN  = 8'h20;
  localparam logic [7:0] OFF_IV   = 8'h40;
  localparam logic [7:0] OFF_DOUT = 8'h60;
  localparam logic [7:0] OFF_CTRL = 8'h80;
  localparam logic [7:0] OFF_STAT = 8'h84;

  state_t        state_q, state_d;
  logic [3:0]    step_q, step_d;
  logic [1:0]    rd_idx_q, rd_idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic          iv_ld_q, iv_ld_d;
  logic [127:0]  key_q, key_d;
  logic [127:0]  iv_q, iv_d;
  logic [127:0]  data_q, data_d;
  logic [127:0]  res_data_q, res_data_d;
  logic          res_err_q, res_err_d;

  logic [7:0]    bank;
  logic [7:0]    wr_off;
  logic [31:0]   wr_dat;
  logic          stat_hit;

  function automatic logic [31:0] word_of(input logic [127:0] v, input logic [1:0] w);
    case (w)
      2'd0:    word_of = v[127:96];
      2'd1:    word_of = v[95:64];
      2'd2:    word_of = v[63:32];
      default: word_of = v[31:0];
    endcase
  endfunction

  // Write steps occupy fixed slots: 0-3 key, 4-7 IV, 8-11 data, 12 trigger, 13 clear.
  always_comb begin
    bank   = mode_q ? 8'h10 : 8'h00;
    wr_off = OFF_CTRL;
    wr_dat = '0;
    case (step_q[3:2])
      2'd0: begin
        wr_off = OFF_KEY + bank + {4'b0, step_q[1:0], 2'b00};
        wr_dat = word_of(key_q, step_q[1:0]);
      end
      2'd1: begin
        wr_off = OFF_IV + bank + {4'b0, step_q[1:0], 2'b00};
        wr_dat = word_of(iv_q, step_q[1:0]);
      end
      2'd2: begin
        wr_off = OFF_DIN + bank + {4'b0, step_q[1:0], 2'b00};
        wr_dat = word_of(data_q, step_q[1:0]);
      end
      default: begin
        wr_off = OFF_CTRL;
        wr_dat = (step_q[1:0] == 2'd0) ? (mode_q ? 32'd2 : 32'd1) : 32'd0;
      end
    endcase
    stat_hit = mode_q ? vprdata[1] : vprdata[0];
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    rd_idx_d   = rd_idx_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    iv_ld_d    = iv_ld_q;
    key_d      = key_q;
    iv_d       = iv_q;
    data_d     = data_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    vpsel      = '0;
    vpenable   = 1'b0;
    vpwrite    = 1'b0;
    vpaddr     = '0;
    vpwdata    = '0;

    case (state_q)
      S_IDLE: begin
        if (job_valid) begin
          mode_d     = job_mode;
          iv_ld_d    = job_iv_ld;
          key_d      = job_key;
          iv_d       = job_iv;
          data_d     = job_data;
          res_data_d = '0;
          res_err_d  = 1'b0;
          cnt_d      = '0;
          rd_idx_d   = '0;
          step_d     = job_key_ld ? 4'd0 : (job_iv_ld ? 4'd4 : 4'd8);
          state_d    = S_WR_SETUP;
        end
      end
      S_WR_SETUP, S_WR_ACCESS: begin
        vpsel[VPINDEX] = 1'b1;
        vpwrite        = 1'b1;
        vpaddr         = VPBASE + {24'h0, wr_off};
        vpwdata        = wr_dat;
        if (state_q == S_WR_SETUP) begin
          state_d = S_WR_ACCESS;
        end else begin
          vpenable = 1'b1;
          state_d  = S_WR_SETUP;
          if (step_q == 4'd13) begin
            cnt_d   = '0;
            state_d = S_SETTLE;
          end else if (step_q == 4'd3) begin
            step_d = iv_ld_q ? 4'd4 : 4'd8;
          end else begin
            step_d = step_q + 4'd1;
          end
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_POLL_SETUP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_POLL_SETUP, S_POLL_ACCESS: begin
        vpsel[VPINDEX] = 1'b1;
        vpaddr         = VPBASE + {24'h0, OFF_STAT};
        if (state_q == S_POLL_SETUP) begin
          state_d = S_POLL_ACCESS;
        end else begin
          vpenable = 1'b1;
          // cnt_q is the zero-based index of the read completing this cycle.
          if (stat_hit) begin
            rd_idx_d = '0;
            state_d  = S_RD_SETUP;
          end else if (cnt_q != POLL_LAST) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_POLL_SETUP;
          end else begin
            res_err_d  = 1'b1;
            res_data_d = '0;
            state_d    = S_DONE;
          end
        end
      end
      S_RD_SETUP, S_RD_ACCESS: begin
        vpsel[VPINDEX] = 1'b1;
        vpaddr         = VPBASE + {24'h0, OFF_DOUT + bank + {4'b0, rd_idx_q, 2'b00}};
        if (state_q == S_RD_SETUP) begin
          state_d = S_RD_ACCESS;
        end else begin
          vpenable = 1'b1;
          case (rd_idx_q)
            2'd0:    res_data_d[127:96] = vprdata;
            2'd1:    res_data_d[95:64]  = vprdata;
            2'd2:    res_data_d[63:32]  = vprdata;
            default: res_data_d[31:0]   = vprdata;
          endcase
          if (rd_idx_q == 2'd3) begin
            state_d = S_DONE;
          end else begin
            rd_idx_d = rd_idx_q + 2'd1;
            state_d  = S_RD_SETUP;
          end
        end
      end
      S_DONE: begin
        if (res_ready) begin
          res_err_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge vclk) begin
    if (vrst) begin
      state_q    <= S_IDLE;
      step_q     <= '0;
      rd_idx_q   <= '0;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      iv_ld_q    <= 1'b0;
      key_q      <= '0;
      iv_q       <= '0;
      data_q     <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      rd_idx_q   <= rd_idx_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      iv_ld_q    <= iv_ld_d;
      key_q      <= key_d;
      iv_q       <= iv_d;
      data_q     <= data_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
    end
  end

  assign job_ready = (state_q == S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;

endmodule
